piece_scheduler: RTL and testbench

Sequencing controller that feeds the game FSM with tetromino shape codes, using the 3-bit shape encoding of nextblock (0-6 valid, 7 invalid).
- Samples the free-running 3-bit random source.
- Enforces a 7-bag rule: each shape appears exactly once per group of 7.
- Keeps a current-plus-preview queue for the next-piece display.
- Hands pieces to the game FSM over a req/ack handshake.

---
 rtl/tetris_pkg.sv | 17 +
 rtl/bag_picker.sv | 33 +++
 rtl/piece_scheduler.sv | 86 ++++++++
 tb/tb_piece_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared shape encoding for the tetromino datapath: 3-bit codes 0-6, with 7 reserved as invalid.
package tetris_pkg;

   localparam int unsigned SHAPE_W    = 3;
   localparam int unsigned NUM_SHAPES = 7;

   localparam logic [SHAPE_W-1:0] SHAPE_INVALID = 3'd7;

   localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd0;
   localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd1;
   localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
   localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd3;
   localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd4;
   localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd5;
   localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd6;

endpackage

// File: rtl/bag_picker.sv
// Combinational 7-bag selector: accepts an unused random shape, or picks the lowest
// unused shape when forced, and produces the updated bag including the wrap to empty.
module bag_picker
   import tetris_pkg::*;
(
   input  logic [NUM_SHAPES-1:0] bag,
   input  logic [SHAPE_W-1:0]    random,
   input  logic                  force_pick,
   output logic                  accept,
   output logic [SHAPE_W-1:0]    pick,
   output logic [NUM_SHAPES-1:0] bag_next
);

   logic [NUM_SHAPES:0]   bag_ext;
   logic [SHAPE_W-1:0]    lowest_free;
   logic [NUM_SHAPES-1:0] marked;

   // Code 7 maps to a permanently "used" slot so it can never be accepted.
   assign bag_ext = {1'b1, bag};

   always_comb begin
      lowest_free = '0;
      for (int i = int'(NUM_SHAPES) - 1; i >= 0; i--) begin
         if (!bag[i]) lowest_free = SHAPE_W'(i);
      end
      accept   = !bag_ext[random];
      pick     = accept ? random : lowest_free;
      marked   = bag | (NUM_SHAPES'(1) << pick);
      bag_next = bag;
      if (accept || force_pick) bag_next = (&marked) ? '0 : marked;
   end

endmodule

// File: rtl/piece_scheduler.sv
// Piece sequencer: fills a current-plus-preview queue from the random source under the
// 7-bag rule and hands the head piece to the game FSM over a req/ack handshake.
module piece_scheduler
   import tetris_pkg::*;
#(
   parameter int unsigned PREVIEW_DEPTH = 3,
   parameter int unsigned MAX_RETRY     = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [SHAPE_W-1:0]                 random,
   input  logic                               spawn_req,
   output logic                               spawn_ack,
   output logic [SHAPE_W-1:0]                 cur_shape,
   output logic [SHAPE_W*PREVIEW_DEPTH-1:0]   preview,
   output logic                               ready
);

   localparam int unsigned DEPTH   = PREVIEW_DEPTH + 1;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   logic [SHAPE_W-1:0]    q [DEPTH];
   logic [CNT_W-1:0]      count;
   logic [NUM_SHAPES-1:0] bag;
   logic [RETRY_W-1:0]    retry;

   logic                  fill;
   logic                  pop;
   logic                  push;
   logic                  force_pick;
   logic                  accept;
   logic [SHAPE_W-1:0]    pick;
   logic [NUM_SHAPES-1:0] bag_next;

   assign ready      = (count == CNT_W'(DEPTH));
   assign fill       = !ready;
   // Guard on spawn_ack so a request still held during the ack cycle is not taken twice.
   assign pop        = spawn_req && ready && !spawn_ack;
   assign force_pick = (retry == RETRY_W'(MAX_RETRY - 1));
   assign push       = fill && (accept || force_pick);

   bag_picker u_bag_picker (
      .bag        (bag),
      .random     (random),
      .force_pick (force_pick),
      .accept     (accept),
      .pick       (pick),
      .bag_next   (bag_next)
   );

   for (genvar i = 0; i < PREVIEW_DEPTH; i++) begin : g_preview
      assign preview[SHAPE_W*i +: SHAPE_W] = q[i+1];
   end

   // Queue, bag, retry and handshake state; pop only when full, push only when not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
         count     <= '0;
         bag       <= '0;
         retry     <= '0;
         spawn_ack <= 1'b0;
         cur_shape <= '0;
      end else begin
         spawn_ack <= pop;
         if (pop) begin
            cur_shape <= q[0];
            for (int i = 0; i < int'(DEPTH) - 1; i++) q[i] <= q[i+1];
            count <= CNT_W'(DEPTH - 1);
         end else if (fill) begin
            if (push) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  if (count == CNT_W'(i)) q[i] <= pick;
               end
               count <= count + CNT_W'(1);
               bag   <= bag_next;
               retry <= '0;
            end else begin
               retry <= retry + RETRY_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: directed scenarios plus randomized traffic
// checked against a queue/bag reference model.
module tb_piece_scheduler;

   localparam int unsigned PD = 3;
   localparam int unsigned MR = 8;
   localparam int D = int'(PD) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [2:0]       rnd = 3'd0;
   logic             spawn_req = 1'b0;
   logic             spawn_ack;
   logic [2:0]       cur_shape;
   logic [3*PD-1:0]  preview;
   logic             ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int mq[$];
   bit mbag[7];
   int mretry;
   bit mack;
   int mcur;
   int dut_hist[$];

   always #5 clk = ~clk;

   piece_scheduler #(.PREVIEW_DEPTH(PD), .MAX_RETRY(MR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .random    (rnd),
      .spawn_req (spawn_req),
      .spawn_ack (spawn_ack),
      .cur_shape (cur_shape),
      .preview   (preview),
      .ready     (ready)
   );

   task automatic model_reset();
      mq.delete();
      for (int s = 0; s < 7; s++) mbag[s] = 1'b0;
      mretry = 0;
      mack   = 1'b0;
      mcur   = 0;
      dut_hist.delete();
   endtask

   task automatic model_step();
      bit pop;
      bit push;
      bit full_bag;
      int c;
      int pk;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pop  = spawn_req && (mq.size() == D) && !mack;
      push = 1'b0;
      pk   = 0;
      if (pop) begin
         mcur = mq.pop_front();
      end else if (mq.size() < D) begin
         c = int'(rnd);
         if (c < 7 && !mbag[c]) begin
            push = 1'b1;
            pk   = c;
         end else if (mretry < int'(MR) - 1) begin
            mretry++;
         end else begin
            push = 1'b1;
            for (int s = 6; s >= 0; s--) if (!mbag[s]) pk = s;
         end
         if (push) begin
            mq.push_back(pk);
            mbag[pk] = 1'b1;
            mretry   = 0;
            full_bag = 1'b1;
            for (int s = 0; s < 7; s++) if (!mbag[s]) full_bag = 1'b0;
            if (full_bag) for (int s = 0; s < 7; s++) mbag[s] = 1'b0;
         end
      end
      mack = pop;
   endtask

   function automatic logic [3*PD-1:0] model_preview();
      logic [3*PD-1:0] p;
      p = '0;
      for (int i = 0; i < int'(PD); i++) p[3*i +: 3] = 3'(mq[i+1]);
      return p;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      if (spawn_ack === 1'b1) dut_hist.push_back(int'(cur_shape));
   endtask

   task automatic test_reset();
      rst_n = 1'b0; spawn_req = 1'b0; rnd = 3'd0;
      model_reset();
      tick(); tick();
      n_tests++;
      if ({spawn_ack, cur_shape, ready} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got ack=%b cur=%0d ready=%b required all 0", spawn_ack, cur_shape, ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         rnd = 3'(k);
         tick();
         n_tests++;
         if (ready !== (k == 3) || spawn_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_step%0d got ready=%b ack=%b required ready=%b ack=0", k, ready, spawn_ack, k == 3);
         end
      end
      n_tests++;
      if (preview !== 9'b011_010_001) begin
         n_fail++;
         $display("FAIL fill_preview got %h required %h", preview, 9'b011_010_001);
      end
   endtask

   task automatic test_handshake();
      spawn_req = 1'b1; rnd = 3'd5;
      tick();
      n_tests++;
      if (spawn_ack !== 1'b1 || cur_shape !== 3'd0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hs_ack got ack=%b cur=%0d ready=%b required 1 0 0", spawn_ack, cur_shape, ready);
      end
      rnd = 3'd7;
      tick();
      n_tests++;
      if (spawn_ack !== 1'b0 || cur_shape !== 3'd0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hs_hold got ack=%b cur=%0d ready=%b required 0 0 0", spawn_ack, cur_shape, ready);
      end
      spawn_req = 1'b0;
   endtask

   task automatic test_reject();
      rnd = 3'd0;
      tick();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_dup got ready=%b required 0", ready);
      end
      rnd = 3'd4;
      tick();
      n_tests++;
      if (ready !== 1'b1 || preview !== {3'd4, 3'd3, 3'd2}) begin
         n_fail++;
         $display("FAIL reject_push got ready=%b preview=%h required 1 %h", ready, preview, {3'd4, 3'd3, 3'd2});
      end
   endtask

   task automatic test_fallback();
      spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      n_tests++;
      if (spawn_ack !== 1'b1 || cur_shape !== 3'd1) begin
         n_fail++;
         $display("FAIL fb_pop got ack=%b cur=%0d required 1 1", spawn_ack, cur_shape);
      end
      rnd = 3'd0;
      for (int k = 0; k < int'(MR); k++) begin
         tick();
         n_tests++;
         if (ready !== (k == int'(MR) - 1)) begin
            n_fail++;
            $display("FAIL fb_cycle%0d got ready=%b required %b", k + 1, ready, k == int'(MR) - 1);
         end
      end
      n_tests++;
      if (preview !== {3'd5, 3'd4, 3'd3}) begin
         n_fail++;
         $display("FAIL fb_preview got %h required %h", preview, {3'd5, 3'd4, 3'd3});
      end
   endtask

   task automatic test_pending();
      bit got;
      spawn_req = 1'b1;
      tick();
      rnd = 3'd7;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (spawn_ack !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_wait%0d got ack=%b ready=%b required 0 0", k, spawn_ack, ready);
         end
      end
      rnd = 3'd6;
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
         tick();
         if (spawn_ack === 1'b1) got = 1'b1;
      end
      n_tests++;
      if (!got || cur_shape !== 3'd3) begin
         n_fail++;
         $display("FAIL pend_ack got acked=%b cur=%0d required 1 3", got, cur_shape);
      end
      spawn_req = 1'b0;
   endtask

   task automatic test_drain();
      int cyc;
      int mask;
      cyc = 0;
      spawn_req = 1'b1;
      while (dut_hist.size() < 14 && cyc < 400) begin
         rnd = 3'(cyc % 8);
         tick();
         cyc++;
      end
      spawn_req = 1'b0;
      n_tests++;
      if (dut_hist.size() < 14) begin
         n_fail++;
         $display("FAIL drain_timeout got %0d pieces required 14", dut_hist.size());
      end else begin
         for (int g = 0; g < 2; g++) begin
            mask = 0;
            for (int i = 0; i < 7; i++) mask |= (1 << dut_hist[7*g + i]);
            n_tests++;
            if (mask !== 32'h7f) begin
               n_fail++;
               $display("FAIL drain_bag%0d got shape mask %h required 7f", g, mask);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         rnd = 3'($urandom_range(0, 7));
         if (!spawn_req && $urandom_range(0, 3) == 0) spawn_req = 1'b1;
         if ($urandom_range(0, 149) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            n_tests++;
            if ({spawn_ack, cur_shape, ready} !== 5'b0) begin
               n_fail++;
               $display("FAIL rnd_reset cyc %0d got ack=%b cur=%0d ready=%b required 0", cyc, spawn_ack, cur_shape, ready);
            end
            spawn_req = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
            if (spawn_ack === 1'b1) spawn_req = 1'($urandom_range(0, 1));
            n_tests++;
            if (spawn_ack !== mack || cur_shape !== 3'(mcur) || ready !== (mq.size() == D)) begin
               n_fail++;
               $display("FAIL rnd_out cyc %0d got ack=%b cur=%0d ready=%b required %b %0d %b",
                        cyc, spawn_ack, cur_shape, ready, mack, mcur, mq.size() == D);
            end
            if (mq.size() == D) begin
               n_tests++;
               if (preview !== model_preview()) begin
                  n_fail++;
                  $display("FAIL rnd_preview cyc %0d got %h required %h", cyc, preview, model_preview());
               end
            end
         end
      end
      spawn_req = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit got;
      got = 1'b0;
      spawn_req = 1'b1;
      for (int k = 0; k < 80 && !got; k++) begin
         rnd = 3'($urandom_range(0, 7));
         tick();
         if (spawn_ack === 1'b1) got = 1'b1;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL mid_wait_ack got no ack required ack within 80 cycles");
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({spawn_ack, cur_shape, ready} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ack got ack=%b cur=%0d ready=%b required 0", spawn_ack, cur_shape, ready);
      end
      spawn_req = 1'b0;
      tick();
      rst_n = 1'b1;
      rnd = 3'd5;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({spawn_ack, cur_shape, ready} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_reset_fill got ack=%b cur=%0d ready=%b required 0", spawn_ack, cur_shape, ready);
      end
      tick();
      rst_n = 1'b1;
      test_fill();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_handshake();
      test_reject();
      test_fallback();
      test_pending();
      test_drain();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish required completion before 2ms");
      $fatal(1, "watchdog");
   end

endmodule
